// File: rtl/fw_pkg.sv
// Shared constants and the sector-fetch state encoding for the firmware streamer.
package fw_pkg;

   localparam int unsigned SECTOR_BYTES = 512;
   localparam int unsigned SECTOR_BITS  = 9;
   localparam int unsigned RAM_AW       = SECTOR_BITS + 1;

   typedef enum logic [1:0] {
      F_IDLE,
      F_REQ,
      F_XFER,
      F_WAIT
   } fetch_state_t;

endpackage

// File: rtl/fw_sector_ram.sv
// Two-sector ping-pong buffer: write port on the SD side, registered read on the drain side.
module fw_sector_ram
   import fw_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [RAM_AW-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic              re,
   input  logic [RAM_AW-1:0] raddr,
   output logic [7:0]        q
);

   logic [7:0] mem [0:(1 << RAM_AW) - 1];

   // Simple dual-port block RAM; q holds its value when re is low.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) q <= mem[raddr];
   end

endmodule

// File: rtl/fw_sector_streamer.sv
// Streams a mounted firmware image out of the SD block interface, double-buffering sectors.
module fw_sector_streamer
   import fw_pkg::*;
#(
   parameter logic [31:0] MAX_BYTES   = 32'd1048576,
   parameter logic [23:0] ACK_TIMEOUT = 24'd12000000
)
(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        img_mounted,
   input  logic [63:0] img_size,
   input  logic        start,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   input  logic        sd_ack,
   input  logic [8:0]  sd_buff_addr,
   input  logic [7:0]  sd_buff_dout,
   input  logic        sd_buff_wr,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] byte_count
);

   fetch_state_t fetch_state, fetch_next;

   logic [31:0] size_q;
   logic [31:0] fetched;
   logic [31:0] rd_count;
   logic [31:0] sect_total;
   logic [23:0] tmo_cnt;
   logic [1:0]  full;
   logic        fill_half;
   logic        ack_q;
   logic        s1_valid;
   logic [7:0]  ram_q;

   logic ack_rise, ack_fall;
   logic size_bad, start_idle, start_ok;
   logic accept, last_accept, free_en, free_half, other_full;
   logic out_free, re, we;
   logic xfer_end, tmo_hit, abort;

   assign size_bad    = (size_q == 32'd0) || (size_q > MAX_BYTES);
   assign start_idle  = start && !busy;
   assign start_ok    = start_idle && !size_bad;
   assign sect_total  = 32'((33'(size_q) + 33'(SECTOR_BYTES - 1)) >> SECTOR_BITS);
   assign ack_rise    = sd_ack && !ack_q;
   assign ack_fall    = !sd_ack && ack_q;
   assign accept      = out_valid && out_ready;
   assign last_accept = accept && (byte_count + 32'd1 == size_q);
   // Sector index of accepted bytes picks the half (sector k always lands in half k%2).
   assign free_en     = accept && ((byte_count[8:0] == 9'd511) || last_accept);
   assign free_half   = byte_count[9];
   assign other_full  = full[~fill_half] && !(free_en && (free_half == ~fill_half));
   assign out_free    = !out_valid || out_ready;
   assign re          = busy && !abort && (rd_count < size_q) && full[rd_count[9]]
                        && (!s1_valid || out_free);
   assign we          = sd_buff_wr && ((fetch_state == F_XFER) ||
                                       ((fetch_state == F_REQ) && ack_rise));

   fw_sector_ram u_ram (
      .clk   (clk_sys),
      .we    (we),
      .waddr ({fill_half, sd_buff_addr}),
      .wdata (sd_buff_dout),
      .re    (re),
      .raddr (rd_count[RAM_AW-1:0]),
      .q     (ram_q)
   );

   // Fetch FSM state register.
   always_ff @(posedge clk_sys) begin
      if (reset) fetch_state <= F_IDLE;
      else       fetch_state <= fetch_next;
   end

   // Fetch FSM next state, sector-complete strobe, timeout and abort decode.
   always_comb begin
      fetch_next = fetch_state;
      xfer_end   = 1'b0;
      tmo_hit    = 1'b0;
      case (fetch_state)
         F_IDLE: if (start_ok) fetch_next = F_REQ;
         F_REQ: begin
            if (ack_rise)                              fetch_next = F_XFER;
            else if (tmo_cnt + 24'd1 == ACK_TIMEOUT)   tmo_hit    = 1'b1;
         end
         F_XFER: begin
            if (ack_fall) begin
               xfer_end = 1'b1;
               if (fetched + 32'd1 >= sect_total) fetch_next = F_IDLE;
               else if (other_full)               fetch_next = F_WAIT;
               else                               fetch_next = F_REQ;
            end
         end
         F_WAIT: if (!full[fill_half]) fetch_next = F_REQ;
         default: fetch_next = F_IDLE;
      endcase
      abort = tmo_hit || (img_mounted && busy);
      if (abort) fetch_next = F_IDLE;
   end

   // SD request side: read strobe, sector address, fill half, fetched count, ack timeout.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         ack_q     <= 1'b0;
         sd_rd     <= 1'b0;
         sd_lba    <= 32'd0;
         fill_half <= 1'b0;
         fetched   <= 32'd0;
         tmo_cnt   <= 24'd0;
      end else begin
         ack_q   <= sd_ack;
         sd_rd   <= (fetch_next == F_REQ);
         tmo_cnt <= (fetch_state == F_REQ) ? tmo_cnt + 24'd1 : 24'd0;
         if (start_idle) begin
            sd_lba    <= 32'd0;
            fill_half <= 1'b0;
            fetched   <= 32'd0;
         end else if (xfer_end && !abort) begin
            sd_lba    <= sd_lba + 32'd1;
            fill_half <= ~fill_half;
            fetched   <= fetched + 32'd1;
         end
      end
   end

   // Half-full flags: set when a sector lands, cleared when its last needed byte is accepted.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         full <= 2'b00;
      end else if (abort || start_idle) begin
         full <= 2'b00;
      end else begin
         if (xfer_end) full[fill_half] <= 1'b1;
         if (free_en)  full[free_half] <= 1'b0;
      end
   end

   // Drain pipeline: RAM read stage then output register, one byte per cycle when ready.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rd_count  <= 32'd0;
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 8'd0;
      end else if (abort || start_idle) begin
         rd_count  <= 32'd0;
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (re) rd_count <= rd_count + 32'd1;
         if (re)            s1_valid <= 1'b1;
         else if (out_free) s1_valid <= 1'b0;
         if (out_free) begin
            out_valid <= s1_valid;
            if (s1_valid) out_data <= ram_q;
         end
      end
   end

   // Session control: stored size, busy/done/error and progress count.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         size_q     <= 32'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         byte_count <= 32'd0;
      end else begin
         done <= 1'b0;
         if (img_mounted)
            size_q <= (img_size[63:32] != 32'd0) ? MAX_BYTES + 32'd1 : img_size[31:0];
         if (start_idle)  byte_count <= 32'd0;
         else if (accept) byte_count <= byte_count + 32'd1;
         if (abort) begin
            busy  <= 1'b0;
            error <= 1'b1;
         end else if (start_idle) begin
            busy  <= !size_bad;
            error <= size_bad;
         end else if (last_accept) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fw_sector_streamer.sv
// Directed bench for fw_sector_streamer with a simple HPS sector responder.
module tb_fw_sector_streamer;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        img_mounted;
   logic [63:0] img_size;
   logic        start;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic        sd_buff_wr;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] byte_count;

   int checks = 0;
   int errors = 0;

   int cur_img;
   bit hps_en;
   bit hps_active;
   int lba_log[$];
   int bc_at_req[$];
   int done_cnt = 0;
   int rd_cycles = 0;

   fw_sector_streamer #(.MAX_BYTES(32'd1048576), .ACK_TIMEOUT(24'd100)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .img_mounted  (img_mounted),
      .img_size     (img_size),
      .start        (start),
      .sd_lba       (sd_lba),
      .sd_rd        (sd_rd),
      .sd_ack       (sd_ack),
      .sd_buff_addr (sd_buff_addr),
      .sd_buff_dout (sd_buff_dout),
      .sd_buff_wr   (sd_buff_wr),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .byte_count   (byte_count)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Image content: byte n of image g.
   function automatic logic [7:0] img_byte(input int g, input int n);
      int sec;
      int off;
      sec = n >> 9;
      off = n & 511;
      return 8'((sec * 37) ^ off ^ ((off >> 8) * 91) ^ (g * 101));
   endfunction

   always @(negedge clk_sys) begin
      if (done)  done_cnt++;
      if (sd_rd) rd_cycles++;
   end

   // HPS model: answers each sd_rd with a 512-byte write burst of the current image.
   initial begin
      sd_ack       = 1'b0;
      sd_buff_wr   = 1'b0;
      sd_buff_addr = 9'd0;
      sd_buff_dout = 8'd0;
      hps_active   = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (hps_en && sd_rd && !sd_ack) begin
            int l;
            int g;
            l = int'(sd_lba);
            g = cur_img;
            hps_active = 1'b1;
            lba_log.push_back(l);
            bc_at_req.push_back(int'(byte_count));
            repeat (2) @(negedge clk_sys);
            sd_ack = 1'b1;
            @(negedge clk_sys);
            for (int i = 0; i < 512; i++) begin
               sd_buff_wr   = 1'b1;
               sd_buff_addr = 9'(i);
               sd_buff_dout = img_byte(g, l * 512 + i);
               @(negedge clk_sys);
            end
            sd_buff_wr = 1'b0;
            @(negedge clk_sys);
            sd_ack     = 1'b0;
            hps_active = 1'b0;
         end
      end
   end

   task automatic mount(input logic [63:0] sz);
      @(negedge clk_sys);
      img_mounted = 1'b1;
      img_size    = sz;
      @(negedge clk_sys);
      img_mounted = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk_sys);
      start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
   endtask

   task automatic wait_hps_idle(input string nm);
      int n;
      n = 0;
      while (hps_active && n < 3000) begin
         @(negedge clk_sys);
         n++;
      end
      check({nm, "_hps_idle"}, 64'(hps_active), 64'd0);
   endtask

   // Stream one image; mode 0 = always ready, 1 = random ready; abort_at>0 remounts mid-stream.
   task automatic stream(input string nm, input int g, input int size, input int mode,
                         input bit do_mount, input int abort_at, input int new_g,
                         input int new_size);
      int acc, cyc, d0, first_cyc, last_cyc, extra_valid;
      bit stall_prev;
      logic [7:0] prev_data, last_data;
      acc = 0; cyc = 0; first_cyc = -1; last_cyc = 0; extra_valid = 0;
      stall_prev = 1'b0; prev_data = 8'd0; last_data = 8'd0;
      lba_log.delete();
      bc_at_req.delete();
      cur_img = g;
      if (do_mount) mount(64'(size));
      pulse_start();
      d0 = done_cnt;
      check({nm, "_busy_on"}, 64'(busy), 64'd1);
      check({nm, "_err_clr"}, 64'(error), 64'd0);
      while (acc < size && cyc < size * 8 + 4000) begin
         @(negedge clk_sys);
         cyc++;
         if (stall_prev)
            check({nm, "_hold"}, 64'({out_valid, out_data}), 64'({1'b1, prev_data}));
         out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            check({nm, "_data"}, 64'(out_data), 64'(img_byte(g, acc)));
            last_data = out_data;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            acc++;
            if (abort_at != 0 && acc == abort_at) break;
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
      end
      if (abort_at != 0) begin
         @(negedge clk_sys);
         check({nm, "_bc_abort"}, 64'(byte_count), 64'(abort_at));
         out_ready   = 1'b0;
         img_mounted = 1'b1;
         img_size    = 64'(new_size);
         cur_img     = new_g;
         @(negedge clk_sys);
         img_mounted = 1'b0;
         check({nm, "_ab_valid"}, 64'(out_valid), 64'd0);
         check({nm, "_ab_err"}, 64'(error), 64'd1);
         check({nm, "_ab_busy"}, 64'(busy), 64'd0);
         check({nm, "_ab_rd"}, 64'(sd_rd), 64'd0);
         wait_hps_idle(nm);
      end else begin
         check({nm, "_count"}, 64'(acc), 64'(size));
         check({nm, "_last"}, 64'(last_data), 64'(img_byte(g, size - 1)));
         @(negedge clk_sys);
         check({nm, "_done"}, 64'(done), 64'd1);
         check({nm, "_bc"}, 64'(byte_count), 64'(size));
         check({nm, "_busy_off"}, 64'(busy), 64'd0);
         for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (out_valid) extra_valid++;
         end
         check({nm, "_no_extra"}, 64'(extra_valid), 64'd0);
         check({nm, "_done_once"}, 64'(done_cnt - d0), 64'd1);
         check({nm, "_nsect"}, 64'(lba_log.size()), 64'((size + 511) / 512));
         for (int i = 0; i < lba_log.size(); i++)
            check({nm, "_lba"}, 64'(lba_log[i]), 64'(i));
         if (mode == 0)
            check({nm, "_bubbles"}, 64'((last_cyc - first_cyc + 1) <= size + 16), 64'd1);
      end
      out_ready = 1'b0;
   endtask

   // Start that must be refused: error set, never busy, no SD request.
   task automatic bad_start(input string nm, input logic [63:0] sz);
      int rc0;
      mount(sz);
      rc0 = rd_cycles;
      pulse_start();
      check({nm, "_err"}, 64'(error), 64'd1);
      check({nm, "_busy"}, 64'(busy), 64'd0);
      repeat (10) @(negedge clk_sys);
      check({nm, "_no_rd"}, 64'(rd_cycles - rc0), 64'd0);
      check({nm, "_err_hold"}, 64'(error), 64'd1);
   endtask

   initial begin
      int n;
      reset       = 1'b1;
      img_mounted = 1'b0;
      img_size    = 64'd0;
      start       = 1'b0;
      out_ready   = 1'b0;
      hps_en      = 1'b1;
      cur_img     = 0;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      check("rst_rd", 64'(sd_rd), 64'd0);
      check("rst_lba", 64'(sd_lba), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(error), 64'd0);
      check("rst_bc", 64'(byte_count), 64'd0);

      stream("t1", 1, 1024, 0, 1'b1, 0, 0, 0);
      stream("t2", 3, 700, 0, 1'b1, 0, 0, 0);
      stream("t3", 4, 2048, 1, 1'b1, 0, 0, 0);
      check("t3_lba2_holdoff", 64'(bc_at_req.size() >= 3 && bc_at_req[2] >= 512), 64'd1);

      bad_start("t4_zero", 64'd0);
      bad_start("t4_big", 64'h1_0000_0000);

      // Ack timeout: HPS stays silent.
      hps_en = 1'b0;
      mount(64'd512);
      pulse_start();
      check("t5_rd_on", 64'(sd_rd), 64'd1);
      n = 0;
      while (!error && n < 300) begin
         @(negedge clk_sys);
         n++;
      end
      check("t5_cycles", 64'(n), 64'd100);
      check("t5_err", 64'(error), 64'd1);
      check("t5_rd_off", 64'(sd_rd), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      hps_en = 1'b1;

      // Remount mid-stream, then restart on the new image.
      stream("t6a", 5, 2048, 0, 1'b1, 300, 6, 600);
      stream("t6b", 6, 600, 0, 1'b0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
